// File: rtl/seven_segment_pkg.sv
//------------------------------------------------------------------------------
// seven_segment_pkg : segment encodings, digit codes and FSM state type
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seven_segment_pkg;

  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_INVALID = 4'hF;

  // Bit order is g..a (bit6..bit0).
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_6_ALT = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_7_ALT = 7'b0100111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_9_ALT = 7'b1100111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  function automatic logic [DIGIT_W-1:0] next_digit(input logic [DIGIT_W-1:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seven_segment_reader_if.sv
//------------------------------------------------------------------------------
// seven_segment_reader_if : decoded-digit valid/ready channel
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface seven_segment_reader_if;
  import seven_segment_pkg::*;

  logic [DIGIT_W-1:0] digit;
  logic               digit_valid;
  logic               digit_ready;
  logic               invalid;

  modport master (output digit, output digit_valid, output invalid, input  digit_ready);
  modport slave  (input  digit, input  digit_valid, input  invalid, output digit_ready);

endinterface

`default_nettype wire

// File: rtl/seven_segment_decode.sv
//------------------------------------------------------------------------------
// seven_segment_decode : combinational segment pattern -> {digit, valid, blank}
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  logic [SEG_W-1:0]   pat_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               valid_o,
  output logic               blank_o
);

  always_comb begin
    digit_o = DIGIT_INVALID;
    valid_o = 1'b1;
    blank_o = 1'b0;
    case (pat_i)
      SEG_0:                 digit_o = 4'd0;
      SEG_1:                 digit_o = 4'd1;
      SEG_2:                 digit_o = 4'd2;
      SEG_3:                 digit_o = 4'd3;
      SEG_4:                 digit_o = 4'd4;
      SEG_5:                 digit_o = 4'd5;
      SEG_6, SEG_6_ALT:      digit_o = 4'd6;
      SEG_7, SEG_7_ALT:      digit_o = 4'd7;
      SEG_8:                 digit_o = 4'd8;
      SEG_9, SEG_9_ALT:      digit_o = 4'd9;
      SEG_BLANK: begin
        valid_o = 1'b0;
        blank_o = 1'b1;
      end
      default:               valid_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_segment_reader.sv
//------------------------------------------------------------------------------
// seven_segment_reader : synchronise, debounce and decode a 7-segment bus,
// check counting order and hand digits out over valid/ready.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seven_segment_reader
  import seven_segment_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  enable_i,
  input  logic [SEG_W-1:0]      seg_i,
  seven_segment_reader_if.master digit_if,
  output logic                  seq_err_o,
  output logic                  overflow_o,
  output logic [CNT_W-1:0]      digit_count_o,
  output logic [CNT_W-1:0]      err_count_o
);

  localparam int             CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][SEG_W-1:0] sync_q;
  logic [SEG_W-1:0]   pat_prev_q, pat_prev_d;
  logic [SEG_W-1:0]   last_pat_q, last_pat_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               enable_q, enable_d;
  state_e             state_q, state_d;
  logic [DIGIT_W-1:0] prev_digit_q, prev_digit_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               valid_q, valid_d;
  logic               invalid_q, invalid_d;
  logic               seq_err_q, seq_err_d;
  logic               overflow_q, overflow_d;
  logic [CNT_W-1:0]   dcount_q, dcount_d;
  logic [CNT_W-1:0]   ecount_q, ecount_d;

  logic [SEG_W-1:0]   pat;
  logic               same, event_fire, enable_rise, load, ld_inv;
  logic [DIGIT_W-1:0] dec_digit, ld_digit;
  logic               dec_valid, dec_blank;
  state_e             state_eff;

  assign pat = sync_q[SYNC_STAGES-1];

  seven_segment_decode u_decode (
    .pat_i   (pat),
    .digit_o (dec_digit),
    .valid_o (dec_valid),
    .blank_o (dec_blank)
  );

  always_comb begin
    pat_prev_d   = pat;
    last_pat_d   = last_pat_q;
    enable_d     = enable_i;
    state_d      = state_q;
    prev_digit_d = prev_digit_q;
    digit_d      = digit_q;
    valid_d      = valid_q;
    invalid_d    = invalid_q;
    seq_err_d    = seq_err_q;
    overflow_d   = overflow_q;
    dcount_d     = dcount_q;
    ecount_d     = ecount_q;
    load         = 1'b0;
    ld_digit     = DIGIT_INVALID;
    ld_inv       = 1'b0;

    // cnt_q counts consecutive cycles the synchronised pattern has not changed.
    same       = (pat == pat_prev_q);
    cnt_d      = !same ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    event_fire = same && (cnt_q == CNT_MAX) && (pat != last_pat_q);

    enable_rise = enable_i && !enable_q;
    state_eff   = enable_rise ? ST_IDLE : state_q;
    state_d     = state_eff;

    if (valid_q && digit_if.digit_ready) begin
      valid_d   = 1'b0;
      invalid_d = 1'b0;
    end

    if (event_fire) begin
      last_pat_d = pat;
      if (enable_i && !dec_blank) begin
        load = 1'b1;
        if (dec_valid) begin
          ld_digit     = dec_digit;
          dcount_d     = (&dcount_q) ? dcount_q : dcount_q + 1'b1;
          if ((state_eff == ST_TRACK) && (dec_digit != next_digit(prev_digit_q))) begin
            seq_err_d = 1'b1;
            ecount_d  = (&ecount_q) ? ecount_q : ecount_q + 1'b1;
          end
          prev_digit_d = dec_digit;
          state_d      = ST_TRACK;
        end else begin
          ld_inv   = 1'b1;
          ecount_d = (&ecount_q) ? ecount_q : ecount_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
    end

    // A pending entry is never overwritten; the new event is dropped instead.
    if (load) begin
      if (valid_q && !digit_if.digit_ready) begin
        overflow_d = 1'b1;
      end else begin
        digit_d   = ld_digit;
        valid_d   = 1'b1;
        invalid_d = ld_inv;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q       <= '0;
      pat_prev_q   <= SEG_BLANK;
      last_pat_q   <= SEG_BLANK;
      cnt_q        <= '0;
      enable_q     <= 1'b0;
      state_q      <= ST_IDLE;
      prev_digit_q <= '0;
      digit_q      <= '0;
      valid_q      <= 1'b0;
      invalid_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      overflow_q   <= 1'b0;
      dcount_q     <= '0;
      ecount_q     <= '0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], seg_i};
      pat_prev_q   <= pat_prev_d;
      last_pat_q   <= last_pat_d;
      cnt_q        <= cnt_d;
      enable_q     <= enable_d;
      state_q      <= state_d;
      prev_digit_q <= prev_digit_d;
      digit_q      <= digit_d;
      valid_q      <= valid_d;
      invalid_q    <= invalid_d;
      seq_err_q    <= seq_err_d;
      overflow_q   <= overflow_d;
      dcount_q     <= dcount_d;
      ecount_q     <= ecount_d;
    end
  end

  assign digit_if.digit       = digit_q;
  assign digit_if.digit_valid = valid_q;
  assign digit_if.invalid     = invalid_q;
  assign seq_err_o            = seq_err_q;
  assign overflow_o           = overflow_q;
  assign digit_count_o        = dcount_q;
  assign err_count_o          = ecount_q;

endmodule

`default_nettype wire
